// File: rtl/reg_dump_sequencer.sv
// rtl/reg_dump_sequencer.sv - steps the CPU register observation select and streams captured words
//
// On a start pulse, walks reg_obs_sel from FIRST_REG to LAST_REG. For each index it
// waits SETTLE_CYCLES edges, captures reg_obs_data, and offers the word on a
// valid/ready stream tagged with the index.
//
// Optional feature macro: REG_DUMP_CHECKSUM_EN adds a running XOR of captured words.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a dump (sampled only when idle)
//   reg_obs_data      observation data returned by the CPU
//   reg_obs_sel       observation select driven to the CPU
//   out_valid/ready   output stream handshake
//   out_idx/out_data  register index and captured value
//   busy              dump in progress
//   done              one-cycle pulse after the last word is accepted
//   checksum          XOR of this dump's words (REG_DUMP_CHECKSUM_EN only)
module reg_dump_sequencer #(
   parameter int FIRST_REG     = 0,
   parameter int LAST_REG      = 31,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] reg_obs_data,
   output logic [4:0]  reg_obs_sel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_idx,
   output logic [31:0] out_data,
   output logic        busy,
   output logic        done
`ifdef REG_DUMP_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   // Counter only has to hold SETTLE_CYCLES-1.
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD  = CW'(SETTLE_CYCLES - 1);
   localparam logic [4:0]    FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0]    LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      EMIT   = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] settle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         reg_obs_sel <= '0;
         out_valid   <= 1'b0;
         out_idx     <= '0;
         out_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         checksum    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Also reached during the done cycle, so a start held there
               // chains straight into the next dump.
               if (start) begin
                  reg_obs_sel <= FIRST_IDX;
                  settle_cnt  <= CNT_LOAD;
                  busy        <= 1'b1;
                  state       <= SETTLE;
`ifdef REG_DUMP_CHECKSUM_EN
                  checksum    <= '0;
`endif
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  out_data  <= reg_obs_data;
                  out_idx   <= reg_obs_sel;
                  out_valid <= 1'b1;
                  state     <= EMIT;
`ifdef REG_DUMP_CHECKSUM_EN
                  checksum  <= checksum ^ reg_obs_data;
`endif
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            EMIT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  // Terminate by comparison so LAST_REG=31 never wraps the select.
                  if (reg_obs_sel == LAST_IDX) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     reg_obs_sel <= reg_obs_sel + 5'd1;
                     settle_cnt  <= CNT_LOAD;
                     state       <= SETTLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb/tb_reg_dump_sequencer.sv - directed self-checking bench for reg_dump_sequencer
module tb_reg_dump_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] obs_data;
   logic [4:0]  sel;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic [31:0] out_data;
   logic        busy;
   logic        done;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [31:0] checksum;
   logic [31:0] checksum2;
`endif

   logic        start2;
   logic [31:0] obs_data2;
   logic [4:0]  sel2;
   logic        out_valid2;
   logic        out_ready2;
   logic [4:0]  out_idx2;
   logic [31:0] out_data2;
   logic        busy2;
   logic        done2;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;

   always #5 clk = ~clk;

   // CPU observation model: 0 -> A5000000|idx, 1 -> idx, 2 -> 1 at idx 0 else 0
   function automatic logic [31:0] model(input int m, input logic [4:0] idx);
      if (m == 0)      return 32'hA500_0000 | {27'd0, idx};
      else if (m == 1) return {27'd0, idx};
      else             return (idx == 5'd0) ? 32'h1 : 32'h0;
   endfunction

   assign obs_data  = model(mode, sel);
   assign obs_data2 = 32'hA500_0000 | {27'd0, sel2};

   reg_dump_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .reg_obs_data(obs_data),
      .reg_obs_sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done)
`ifdef REG_DUMP_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   reg_dump_sequencer #(.FIRST_REG(5), .LAST_REG(5), .SETTLE_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .reg_obs_data(obs_data2),
      .reg_obs_sel(sel2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_idx(out_idx2), .out_data(out_data2), .busy(busy2), .done(done2)
`ifdef REG_DUMP_CHECKSUM_EN
      , .checksum(checksum2)
`endif
   );

   // Runs one default-parameter dump with out_ready=1; optionally pulses start at cycle mid_c.
   // Cycle 0 is the start edge; returns just after the done edge.
   task automatic run_dump(input int mid_c, output int words, output int errs,
                           output int done_c, output logic [31:0] csum);
      words  = 0;
      errs   = 0;
      done_c = -1;
      csum   = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         start = (c == mid_c) ? 1'b1 : 1'b0;
         if (done) begin
            done_c = c;
`ifdef REG_DUMP_CHECKSUM_EN
            csum = checksum;
`endif
            start = 1'b0;
            break;
         end
         if (out_valid) begin
            if (out_idx !== 5'(words) || out_data !== model(mode, 5'(words))) errs++;
            words++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
      #3;
      checks++;
      if ({sel, out_valid, out_idx, out_data, busy, done} !== 40'd0) begin
         failures++;
         $display("FAIL reset_outputs got sel=%0d v=%0b idx=%0d data=%h busy=%0b done=%0b want all 0",
                  sel, out_valid, out_idx, out_data, busy, done);
      end
`ifdef REG_DUMP_CHECKSUM_EN
      checks++;
      if (checksum !== 32'h0) begin
         failures++; $display("FAIL reset_checksum got %h want 00000000", checksum);
      end
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset got busy=%0b v=%0b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_full_dump();
      int w, e, dc;
      logic [31:0] cs;
      mode = 0;
      run_dump(-1, w, e, dc, cs);
      checks++;
      if (w !== 32) begin failures++; $display("FAIL full_word_count got %0d want 32", w); end
      checks++;
      if (e !== 0) begin failures++; $display("FAIL full_word_content got %0d bad words want 0", e); end
      checks++;
      if (dc !== 64) begin failures++; $display("FAIL full_done_cycle got %0d want 64", dc); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_at_done got %0b want 0", busy); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL full_done_pulse_width got done=%0b busy=%0b want 0 0", done, busy);
      end
      checks++;
      if (sel !== 5'd31) begin failures++; $display("FAIL full_sel_hold got %0d want 31", sel); end
   endtask

   task automatic test_backpressure();
      int words = 0;
      bit stalled = 0;
      bit seen_done = 0;
      mode = 0;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 250 && !seen_done; c++) begin
         @(posedge clk); #1;
         if (done) seen_done = 1;
         else if (out_valid) begin
            if (out_idx == 5'd3 && !stalled) begin
               stalled = 1;
               out_ready = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  @(posedge clk); #1;
                  checks++;
                  if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'hA500_0003 || sel !== 5'd3) begin
                     failures++;
                     $display("FAIL stall_hold[%0d] got v=%0b idx=%0d data=%h sel=%0d want 1 3 a5000003 3",
                              k, out_valid, out_idx, out_data, sel);
                  end
               end
               out_ready = 1'b1;
            end
            checks++;
            if (out_idx !== 5'(words)) begin
               failures++; $display("FAIL stall_order got idx=%0d want %0d", out_idx, words);
            end
            words++;
         end
      end
      checks++;
      if (!seen_done || words !== 32) begin
         failures++; $display("FAIL stall_word_count got %0d done=%0b want 32 1", words, seen_done);
      end
   endtask

   task automatic test_single_reg();
      int vc = -1;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (out_valid2) begin vc = c; break; end
      end
      checks++;
      if (vc + 1 !== 4) begin failures++; $display("FAIL single_latency got %0d edges want 4", vc + 1); end
      checks++;
      if (out_idx2 !== 5'd5 || out_data2 !== 32'hA500_0005) begin
         failures++; $display("FAIL single_word got idx=%0d data=%h want 5 a5000005", out_idx2, out_data2);
      end
      @(posedge clk); #1;
      checks++;
      if (done2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || sel2 !== 5'd5) begin
         failures++;
         $display("FAIL single_done got done=%0b v=%0b busy=%0b sel=%0d want 1 0 0 5", done2, out_valid2, busy2, sel2);
      end
   endtask

   task automatic test_back_to_back();
      int w, e, dc;
      logic [31:0] cs;
      int dc2 = -1;
      mode = 0;
      run_dump(5, w, e, dc, cs);
      checks++;
      if (w !== 32 || e !== 0 || dc !== 64) begin
         failures++; $display("FAIL busy_start_ignored got words=%0d bad=%0d done_c=%0d want 32 0 64", w, e, dc);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || sel !== 5'd0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL done_cycle_start got busy=%0b sel=%0d v=%0b want 1 0 0", busy, sel, out_valid);
      end
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (done) begin dc2 = c; break; end
      end
      checks++;
      if (dc2 !== 64) begin failures++; $display("FAIL chained_done_cycle got %0d want 64", dc2); end
   endtask

   task automatic test_reset_mid_dump();
      int w, e, dc;
      logic [31:0] cs;
      bit hit = 0;
      bit saw_done = 0;
      mode = 0;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (out_valid && out_idx == 5'd10) begin hit = 1; break; end
      end
      checks++;
      if (!hit) begin failures++; $display("FAIL reach_idx10 got timeout want idx 10"); end
      rst_n = 1'b0;
      #2;
      checks++;
      if ({sel, out_valid, out_idx, out_data, busy, done} !== 40'd0) begin
         failures++;
         $display("FAIL async_reset got sel=%0d v=%0b idx=%0d data=%h busy=%0b done=%0b want all 0",
                  sel, out_valid, out_idx, out_data, busy, done);
      end
      repeat (2) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      checks++;
      if (saw_done) begin failures++; $display("FAIL reset_no_done got done pulse want none"); end
      run_dump(-1, w, e, dc, cs);
      checks++;
      if (w !== 32 || e !== 0 || dc !== 64) begin
         failures++; $display("FAIL restart_dump got words=%0d bad=%0d done_c=%0d want 32 0 64", w, e, dc);
      end
   endtask

`ifdef REG_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      int w, e, dc;
      logic [31:0] cs;
      mode = 1;
      run_dump(-1, w, e, dc, cs);
      checks++;
      if (cs !== 32'h0) begin failures++; $display("FAIL checksum_idx got %h want 00000000", cs); end
      mode = 2;
      run_dump(-1, w, e, dc, cs);
      checks++;
      if (cs !== 32'h1) begin failures++; $display("FAIL checksum_one got %h want 00000001", cs); end
      @(posedge clk); #1;
      checks++;
      if (checksum !== 32'h1) begin failures++; $display("FAIL checksum_stable got %h want 00000001", checksum); end
   endtask
`endif

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_single_reg();
      test_back_to_back();
      test_reset_mid_dump();
`ifdef REG_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
